// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared widths, latency and state encoding for the multiplier
package mult_pkg;
    localparam int QW      = 8;
    localparam int DW      = 7;
    localparam int PW      = QW + DW;
    localparam int LATENCY = 17;
    localparam int CW      = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;
endpackage

// File: rtl/mult_datapath.sv
// rtl/mult_datapath.sv - shift-add accumulator: acc = quotient * divisor + remainder
module mult_datapath
    import mult_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic          step,
    input  logic [QW-1:0] quotientin,
    input  logic [DW-1:0] divisorin,
    input  logic [DW-1:0] remainderin,
    output logic [PW-1:0] acc
);
    logic [PW-1:0] mcand;
    logic [DW-1:0] mplier;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
        end else if (load) begin
            acc    <= {{QW{1'b0}}, remainderin};
            mcand  <= {{DW{1'b0}}, quotientin};
            mplier <= divisorin;
        end else if (step) begin
            if (mplier[0])
                acc <= acc + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
        end
    end
endmodule

// File: rtl/multiplier.sv
// rtl/multiplier.sv - fixed-latency multiply-accumulate sharing the divider's start/valid protocol
module multiplier
    import mult_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [QW-1:0] quotientin,
    input  logic [DW-1:0] divisorin,
    input  logic [DW-1:0] remainderin,
    output logic [PW-1:0] product,
    output logic          valid
);
    state_t        state, next_state;
    logic [CW-1:0] cnt;
    logic          load, step, done_hit;
    logic [PW-1:0] acc;

    mult_datapath u_datapath (
        .clk         (clk),
        .reset       (reset),
        .load        (load),
        .step        (step),
        .quotientin  (quotientin),
        .divisorin   (divisorin),
        .remainderin (remainderin),
        .acc         (acc)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= next_state;
    end

    // cnt tracks edges since the start edge; it reads 1 on the first RUN cycle
    always_comb begin
        next_state = state;
        load       = 1'b0;
        step       = 1'b0;
        done_hit   = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start)
                    next_state = LOAD;
            end
            LOAD: begin
                load       = 1'b1;
                next_state = start ? LOAD : RUN;
            end
            RUN: begin
                step     = (cnt <= CW'(DW));
                done_hit = (cnt == CW'(LATENCY - 1));
                if (start)
                    next_state = LOAD;
                else if (done_hit)
                    next_state = DONE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt <= '0;
        else if (start)
            cnt <= '0;
        else if (state == LOAD || state == RUN)
            cnt <= cnt + CW'(1);
    end

    // a start on the completion edge still publishes the result but withholds valid
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            product <= '0;
            valid   <= 1'b0;
        end else begin
            if (done_hit)
                product <= acc;
            if (start)
                valid <= 1'b0;
            else if (done_hit)
                valid <= 1'b1;
        end
    end
endmodule
